pseudo_spi_intf: RTL and testbench

PSEUDO_SPI_INTF -- requirements
Module: pseudo_spi_intf

---
 rtl/pseudo_spi_intf_pkg.sv | 20 ++
 rtl/pseudo_spi_intf.sv | 143 ++++++++++++++
 tb/tb_pseudo_spi_intf.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pseudo_spi_intf_pkg.sv
// Shared definitions for the pseudo-SPI SRAM streamer: default widths and
// the 3-bit FSM state encodings.
package pseudo_spi_intf_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    // Encodings are fixed so that state values stay stable for debug probes.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_ADDR = 3'b001,
        ST_READ = 3'b011,
        ST_SOUT = 3'b010,
        ST_LOOP = 3'b110,
        ST_RDY  = 3'b100,
        ST_DONE = 3'b101
    } state_t;

endpackage

// File: rtl/pseudo_spi_intf.sv
// Pseudo-SPI streamer: reads DATA_LEN+1 bytes from a synchronous SRAM,
// starting at ADDR_BGN and walking downward, and shifts each byte out
// LSB first using a two-phase serial clock (SCLK1 then SCLK2), with a
// LAT strobe after every byte. All outputs are decoded from the state
// (Moore), so an asynchronous reset forces them immediately.
module pseudo_spi_intf
    import pseudo_spi_intf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BGN,
    input  logic [ADDR_W-1:0] ADDR_BGN,
    input  logic [LEN_W-1:0]  DATA_LEN,
    input  logic [DATA_W-1:0] PI,
    output logic              SCLK1,
    output logic              SCLK2,
    output logic              LAT,
    output logic              SPI_SO,
    output logic              CEN,
    output logic [ADDR_W-1:0] A,
    output logic              D_WE,
    output logic              spi_is_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LEN_W-1:0]    byte_cnt_reg, byte_cnt_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0]   shreg_reg, shreg_next;

    // The SRAM is only ever read.
    assign D_WE = 1'b1;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            byte_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            byte_cnt_reg <= byte_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shreg_reg    <= shreg_next;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        byte_cnt_next = byte_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shreg_next    = shreg_reg;

        SCLK1       = 1'b0;
        SCLK2       = 1'b0;
        LAT         = 1'b0;
        SPI_SO      = 1'b0;
        CEN         = 1'b1;
        A           = '0;
        spi_is_done = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (BGN) begin
                    state_next    = ST_ADDR;
                    addr_next     = ADDR_BGN;
                    byte_cnt_next = '0;
                    bit_cnt_next  = '0;
                end
            end
            ST_ADDR: begin
                // Address presented here; SRAM data appears next cycle.
                CEN        = 1'b0;
                A          = addr_reg;
                state_next = ST_READ;
            end
            ST_READ: begin
                CEN        = 1'b0;
                A          = addr_reg;
                shreg_next = PI;
                state_next = ST_SOUT;
            end
            ST_SOUT: begin
                SCLK1      = 1'b1;
                SPI_SO     = shreg_reg[0];
                state_next = ST_LOOP;
            end
            ST_LOOP: begin
                // Shift happens at the end of LOOP so SPI_SO is steady
                // across the whole SOUT/LOOP pair.
                SCLK2      = 1'b1;
                SPI_SO     = shreg_reg[0];
                shreg_next = shreg_reg >> 1;
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    state_next   = ST_RDY;
                end else begin
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    state_next   = ST_SOUT;
                end
            end
            ST_RDY: begin
                LAT = 1'b1;
                if (byte_cnt_reg == DATA_LEN) begin
                    state_next = ST_DONE;
                end else begin
                    // Downward walk wraps naturally at 0.
                    addr_next     = addr_reg - ADDR_W'(1);
                    byte_cnt_next = byte_cnt_reg + LEN_W'(1);
                    state_next    = ST_ADDR;
                end
            end
            ST_DONE: begin
                spi_is_done = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Dropping BGN abandons any transfer in progress.
        if (state_reg != ST_IDLE && !BGN) begin
            state_next    = ST_IDLE;
            addr_next     = addr_reg;
            byte_cnt_next = byte_cnt_reg;
            bit_cnt_next  = bit_cnt_reg;
            shreg_next    = shreg_reg;
        end
    end

endmodule

// File: tb/tb_pseudo_spi_intf.sv
// Directed bench for pseudo_spi_intf with a synchronous-read SRAM model.
module tb_pseudo_spi_intf;

    logic       clk = 1'b0;
    logic       rst;
    logic       bgn;
    logic [8:0] addr_bgn;
    logic [7:0] data_len;
    logic [7:0] pi;
    logic       sclk1, sclk2, lat, spi_so, cen, d_we, spi_is_done;
    logic [8:0] a;

    logic [7:0] mem [512];

    int tests = 0;
    int fails = 0;

    // Capture results of one transfer.
    logic [7:0] bytes_q [$];
    int         addrs_q [$];
    int         loops_q [$];
    logic       bits_q  [$];
    int         lat_cnt;
    int         so_bad;
    logic       done_seen;

    always #5 clk = ~clk;

    pseudo_spi_intf dut (
        .CLK        (clk),
        .RST        (rst),
        .BGN        (bgn),
        .ADDR_BGN   (addr_bgn),
        .DATA_LEN   (data_len),
        .PI         (pi),
        .SCLK1      (sclk1),
        .SCLK2      (sclk2),
        .LAT        (lat),
        .SPI_SO     (spi_so),
        .CEN        (cen),
        .A          (a),
        .D_WE       (d_we),
        .spi_is_done(spi_is_done)
    );

    // Synchronous-read SRAM: data for the address seen at an edge is
    // available after that edge.
    always @(posedge clk) begin
        if (!cen && d_we) pi <= mem[a];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sclk1"}, sclk1, 1'b0);
        check({tag, "_sclk2"}, sclk2, 1'b0);
        check({tag, "_lat"},   lat, 1'b0);
        check({tag, "_so"},    spi_so, 1'b0);
        check({tag, "_cen"},   cen, 1'b1);
        check({tag, "_a"},     a, 9'd0);
        check({tag, "_dwe"},   d_we, 1'b1);
        check({tag, "_done"},  spi_is_done, 1'b0);
    endtask

    // Start a transfer from IDLE and record everything until DONE.
    task automatic run_xfer(input int addr, input int len, input int budget);
        logic       prev_cen;
        logic       sout_so;
        logic [7:0] cur;
        int         nbits;
        bytes_q.delete(); addrs_q.delete(); loops_q.delete(); bits_q.delete();
        lat_cnt = 0; so_bad = 0; done_seen = 1'b0;
        prev_cen = 1'b1; sout_so = 1'b0; cur = '0; nbits = 0;
        addr_bgn = 9'(addr);
        data_len = 8'(len);
        bgn = 1'b1;
        for (int c = 1; c <= budget && !done_seen; c++) begin
            tick();
            if (!cen && prev_cen) addrs_q.push_back(int'(a));
            prev_cen = cen;
            if (sclk1) sout_so = spi_so;
            if (sclk2) begin
                loops_q.push_back(c);
                bits_q.push_back(spi_so);
                if (spi_so !== sout_so) so_bad++;
                cur[nbits] = spi_so;
                nbits++;
                if (nbits == 8) begin
                    bytes_q.push_back(cur);
                    nbits = 0;
                end
            end
            if (lat) lat_cnt++;
            if (spi_is_done) done_seen = 1'b1;
        end
        check("done_reached", done_seen, 1'b1);
    endtask

    initial begin
        logic [7:0] exp24 [14];
        logic [7:0] exp_bits;
        int         found;

        exp24 = '{8'hC2, 8'h01, 8'h7A, 8'h58, 8'hD7, 8'hC3, 8'h9E,
                  8'h3D, 8'h05, 8'h00, 8'h3C, 8'h00, 8'h00, 8'hAB};
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[32] = 8'hAB; mem[33] = 8'h00; mem[34] = 8'h00; mem[35] = 8'h3C;
        mem[36] = 8'h00; mem[37] = 8'h05; mem[38] = 8'h3D; mem[39] = 8'h9E;
        mem[40] = 8'hC3; mem[41] = 8'hD7; mem[42] = 8'h58; mem[43] = 8'h7A;
        mem[44] = 8'h01; mem[45] = 8'hC2;
        mem[7]  = 8'h96;
        mem[1]  = 8'h22; mem[0] = 8'h11; mem[511] = 8'h5A;

        rst = 1'b1; bgn = 1'b0; addr_bgn = '0; data_len = '0;
        #3;
        check_reset_outputs("reset");
        #20;
        rst = 1'b0;
        tick();
        check("idle_cen", cen, 1'b1);

        // 14-byte stream from 45 down to 32.
        run_xfer(45, 13, 400);
        check("s24_nbytes", bytes_q.size(), 14);
        for (int k = 0; k < 14 && k < bytes_q.size(); k++)
            check($sformatf("s24_byte%0d", k), bytes_q[k], exp24[k]);
        check("s24_naddr", addrs_q.size(), 14);
        for (int k = 0; k < 14 && k < addrs_q.size(); k++)
            check($sformatf("s24_addr%0d", k), addrs_q[k], 45 - k);
        check("s24_lat", lat_cnt, 14);
        check("s24_so_stable", so_bad, 0);
        check("s24_first_loop", loops_q.size() > 0 ? loops_q[0] : -1, 4);
        check("s24_loop_period", loops_q.size() > 1 ? loops_q[1] - loops_q[0] : -1, 2);
        check("s24_byte_gap", loops_q.size() > 8 ? loops_q[8] - loops_q[7] : -1, 5);
        tick();
        check("s24_done_hold", spi_is_done, 1'b1);
        bgn = 1'b0;
        tick();
        check("s24_idle_done", spi_is_done, 1'b0);
        check("s24_idle_cen", cen, 1'b1);

        // Single byte 0x96 at address 7.
        run_xfer(7, 0, 60);
        exp_bits = 8'b1001_0110;
        check("s25_nbits", bits_q.size(), 8);
        for (int k = 0; k < 8 && k < bits_q.size(); k++)
            check($sformatf("s25_bit%0d", k), bits_q[k], exp_bits[k]);
        check("s25_lat", lat_cnt, 1);
        check("s25_addr", addrs_q.size() > 0 ? addrs_q[0] : -1, 7);
        bgn = 1'b0;
        tick();

        // Address wrap from 0 to 511.
        run_xfer(1, 2, 120);
        check("s26_naddr", addrs_q.size(), 3);
        check("s26_addr0", addrs_q.size() > 0 ? addrs_q[0] : -1, 1);
        check("s26_addr1", addrs_q.size() > 1 ? addrs_q[1] : -1, 0);
        check("s26_addr2", addrs_q.size() > 2 ? addrs_q[2] : -1, 511);
        check("s26_lat", lat_cnt, 3);
        check("s26_byte2", bytes_q.size() > 2 ? bytes_q[2] : 8'hXX, 8'h5A);
        bgn = 1'b0;
        tick();

        // Abort during the second byte, then restart.
        addr_bgn = 9'd45; data_len = 8'd13; bgn = 1'b1;
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            tick();
            if (!cen && a == 9'd44) found = 1;
        end
        check("s27_second_byte", found, 1);
        tick(); tick(); tick(); tick();
        bgn = 1'b0;
        tick();
        check("s27_abort_cen", cen, 1'b1);
        check("s27_abort_done", spi_is_done, 1'b0);
        check("s27_abort_sclk", {sclk1, sclk2, lat}, 3'b000);
        tick();
        check("s27_stay_idle", cen, 1'b1);
        bgn = 1'b1;
        tick();
        check("s27_restart_a", a, 9'd45);
        check("s27_restart_cen", cen, 1'b0);

        // Reset asserted while in LOOP, between clock edges.
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick();
            if (sclk2) found = 1;
        end
        check("s28_in_loop", found, 1);
        rst = 1'b1;
        #2;
        check_reset_outputs("s28_async");
        bgn = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        check("s28_idle_cen", cen, 1'b1);
        check("s28_idle_done", spi_is_done, 1'b0);
        addr_bgn = 9'd7;
        bgn = 1'b1;
        tick();
        check("s28_restart_a", a, 9'd7);
        bgn = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
